// File: rtl/jtframe_sdram_arb3_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : jtframe_sdram_arb3_if                                           |
// | Purpose  : Bundle of the three request slots and the SDRAM controller     |
// |            port served by jtframe_sdram_arb3.                              |
// | Ports    : slot_req/rnw/addr/wdata  -> requests from the three slots      |
// |            slot_we/dok/dout         <- accept, done strobes and read data |
// |            sdram_req/rnw/addr/wrdata-> transaction to the controller      |
// |            sdram_ack/rdy/din        <- controller handshake and read data |
// |            busy, tout_err           <- status                             |
// |            master = arbiter view, slave = requesters + controller view.   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface jtframe_sdram_arb3_if #(
  parameter int DW = 16
);
  logic [2:0]      slot_req;
  logic [2:0]      slot_rnw;
  logic [65:0]     slot_addr;
  logic [3*DW-1:0] slot_wdata;
  logic [2:0]      slot_we;
  logic [2:0]      slot_dok;
  logic [31:0]     slot_dout;
  logic            sdram_req;
  logic            sdram_rnw;
  logic [21:0]     sdram_addr;
  logic [31:0]     sdram_wrdata;
  logic            sdram_ack;
  logic            sdram_rdy;
  logic [31:0]     sdram_din;
  logic            busy;
  logic            tout_err;

  modport master (
    input  slot_req, slot_rnw, slot_addr, slot_wdata,
    output slot_we, slot_dok, slot_dout,
    output sdram_req, sdram_rnw, sdram_addr, sdram_wrdata,
    input  sdram_ack, sdram_rdy, sdram_din,
    output busy, tout_err
  );

  modport slave (
    output slot_req, slot_rnw, slot_addr, slot_wdata,
    input  slot_we, slot_dok, slot_dout,
    input  sdram_req, sdram_rnw, sdram_addr, sdram_wrdata,
    output sdram_ack, sdram_rdy, sdram_din,
    input  busy, tout_err
  );
endinterface
`default_nettype wire

// File: rtl/jtframe_sdram_arb3.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : jtframe_sdram_arb3                                              |
// | Purpose  : Round-robin arbiter sharing one SDRAM controller port between  |
// |            three read/write request slots, with a per-transaction timeout.|
// | Ports    : clk, rst (async, active-high)                                   |
// |            bus : jtframe_sdram_arb3_if.master (slot and controller sides) |
// | Params   : DW   slot write-data width (<= 32), zero-extended to 32 bits   |
// |            TOUT max cycles from grant to sdram_rdy (4..1023)              |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module jtframe_sdram_arb3 #(
  parameter int DW   = 16,
  parameter int TOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  jtframe_sdram_arb3_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    WAIT_RDY = 2'd2
  } state_t;

  // Timer counts wait cycles since the grant; the abort fires on the
  // TOUT-th wait cycle, i.e. when the pre-increment value is TOUT-1.
  localparam logic [9:0] c_tout_last = 10'(TOUT - 1);

  state_t       r_state;
  logic [1:0]   r_last;
  logic [1:0]   r_g;
  logic [9:0]   r_timer;
  logic         r_sdram_req;
  logic         r_sdram_rnw;
  logic [21:0]  r_sdram_addr;
  logic [31:0]  r_sdram_wrdata;
  logic [31:0]  r_slot_dout;
  logic [2:0]   r_slot_we;
  logic [2:0]   r_slot_dok;
  logic         r_busy;
  logic         r_tout_err;

  logic [21:0]   w_addr  [3];
  logic [DW-1:0] w_wdata [3];
  logic [1:0]    w_c1;
  logic [1:0]    w_c2;
  logic [1:0]    w_pick;
  logic          w_any;
  logic          w_tout;
  logic [2:0]    w_g_hot;

  for (genvar k = 0; k < 3; k++) begin : g_slot
    assign w_addr[k]  = bus.slot_addr[22*k +: 22];
    assign w_wdata[k] = bus.slot_wdata[DW*k +: DW];
  end

  // Search order last+1, last+2, last (mod 3); the last winner has the
  // lowest priority, so it is only picked when nobody else asks.
  assign w_c1    = (r_last == 2'd2) ? 2'd0 : r_last + 2'd1;
  assign w_c2    = (w_c1   == 2'd2) ? 2'd0 : w_c1   + 2'd1;
  assign w_pick  = bus.slot_req[w_c1] ? w_c1 :
                   bus.slot_req[w_c2] ? w_c2 : r_last;
  assign w_any   = |bus.slot_req;
  assign w_tout  = (r_timer == c_tout_last);
  assign w_g_hot = 3'b001 << r_g;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= IDLE;
      r_last         <= 2'd2;
      r_g            <= 2'd0;
      r_timer        <= 10'd0;
      r_sdram_req    <= 1'b0;
      r_sdram_rnw    <= 1'b1;
      r_sdram_addr   <= 22'd0;
      r_sdram_wrdata <= 32'd0;
      r_slot_dout    <= 32'd0;
      r_slot_we      <= 3'd0;
      r_slot_dok     <= 3'd0;
      r_busy         <= 1'b0;
      r_tout_err     <= 1'b0;
    end else begin
      r_slot_we  <= 3'd0;
      r_slot_dok <= 3'd0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_sdram_rnw    <= bus.slot_rnw[w_pick];
            r_sdram_addr   <= w_addr[w_pick];
            r_sdram_wrdata <= 32'(w_wdata[w_pick]);
            r_sdram_req    <= 1'b1;
            r_g            <= w_pick;
            r_last         <= w_pick;
            r_timer        <= 10'd0;
            r_busy         <= 1'b1;
            r_state        <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          r_timer <= r_timer + 10'd1;
          if (bus.sdram_ack) begin
            r_sdram_req <= 1'b0;
            r_slot_we   <= w_g_hot;
            if (bus.sdram_rdy) begin
              // Accept and completion collapsed into one cycle.
              r_slot_dout <= bus.sdram_din;
              r_slot_dok  <= w_g_hot;
              r_busy      <= 1'b0;
              r_state     <= IDLE;
            end else if (w_tout) begin
              // Accept stands, but the transaction is abandoned.
              r_tout_err  <= 1'b1;
              r_busy      <= 1'b0;
              r_state     <= IDLE;
            end else begin
              r_state     <= WAIT_RDY;
            end
          end else if (w_tout) begin
            r_sdram_req <= 1'b0;
            r_tout_err  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        WAIT_RDY: begin
          r_timer <= r_timer + 10'd1;
          if (bus.sdram_rdy) begin
            // Captured on writes too; requesters simply ignore it.
            r_slot_dout <= bus.sdram_din;
            r_slot_dok  <= w_g_hot;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end else if (w_tout) begin
            r_tout_err  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_sdram_req <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.sdram_req    = r_sdram_req;
  assign bus.sdram_rnw    = r_sdram_rnw;
  assign bus.sdram_addr   = r_sdram_addr;
  assign bus.sdram_wrdata = r_sdram_wrdata;
  assign bus.slot_we      = r_slot_we;
  assign bus.slot_dok     = r_slot_dok;
  assign bus.slot_dout    = r_slot_dout;
  assign bus.busy         = r_busy;
  assign bus.tout_err     = r_tout_err;

endmodule
`default_nettype wire
